// File: rtl/scoreboard_display_capture.sv
// scoreboard_display_capture: samples the muxed 7-segment bus, decodes stable digits and rebuilds both BCD scores.
// Optional saturating decode-error counter built when SCOREBOARD_CAPTURE_ERRCNT_EN is defined.
module scoreboard_display_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] segments_i,
    input  logic [3:0] segment_select_i,
    output logic [7:0] p1_score_o,
    output logic [7:0] p2_score_o,
    output logic       frame_valid_o,
    output logic       decode_err_o,
    output logic [7:0] err_count_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    state_t state, state_n;
    logic [10:0] s_q;
    logic [CNT_W-1:0] count;
    logic captured;
    logic [3:0] seen;
    logic [3:0] digit [4];
    logic [3:0] dec;
    logic legal, changed, capture, commit;
    assign changed = {segment_select_i, segments_i} != s_q;
    // Only a pattern that has held unchanged through the whole window is captured.
    assign capture = !changed && count == LAST && !captured && $onehot(segment_select_i);
    assign commit = state == COLLECT && seen == 4'hF;
    assign frame_valid_o = state == COMMIT;
    always_comb begin
        dec = 4'd0;
        legal = 1'b1;
        case (segments_i)
            7'h3F, 7'h00: dec = 4'd0;
            7'h06: dec = 4'd1;
            7'h5B: dec = 4'd2;
            7'h4F: dec = 4'd3;
            7'h66: dec = 4'd4;
            7'h6D: dec = 4'd5;
            7'h7D: dec = 4'd6;
            7'h07: dec = 4'd7;
            7'h7F: dec = 4'd8;
            7'h6F: dec = 4'd9;
            default: legal = 1'b0;
        endcase
    end
    always_comb
        state_n = state == COMMIT ? IDLE :
                  state == IDLE ? (capture && legal ? COLLECT : IDLE) :
                  commit ? COMMIT : (capture && !legal ? IDLE : COLLECT);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            s_q <= '0;
            count <= '0;
            captured <= 1'b0;
            seen <= 4'h0;
            p1_score_o <= 8'h00;
            p2_score_o <= 8'h00;
            decode_err_o <= 1'b0;
            for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
        end else begin
            state <= state_n;
            s_q <= {segment_select_i, segments_i};
            if (changed) begin
                count <= '0;
                captured <= 1'b0;
            end else begin
                if (count != LAST) count <= count + 1'b1;
                if (capture) captured <= 1'b1;
            end
            decode_err_o <= capture && !legal;
            if (commit) begin
                p1_score_o <= {digit[1], digit[0]};
                p2_score_o <= {digit[3], digit[2]};
                seen <= 4'h0;
            end else if (capture) begin
                seen <= legal ? seen | segment_select_i : 4'h0;
            end
            for (int i = 0; i < 4; i++)
                if (capture && legal && segment_select_i[i]) digit[i] <= dec;
        end
    end
`ifdef SCOREBOARD_CAPTURE_ERRCNT_EN
    logic [7:0] err_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 8'h00;
        else if (decode_err_o && err_q != 8'hFF) err_q <= err_q + 8'h01;
    end
    assign err_count_o = err_q;
`else
    assign err_count_o = 8'h00;
`endif
endmodule

// File: tb/tb_scoreboard_display_capture.sv
// tb_scoreboard_display_capture: directed and random display-bus traffic checked against a digit-level score model.
module tb_scoreboard_display_capture;
    localparam int ST = 4;
    localparam logic [6:0] LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] segments = 7'h00;
    logic [3:0] segment_select = 4'h0;
    logic [7:0] p1, p2, ec;
    logic fv, de;
    int tests = 0, fails = 0, frames = 0, errs = 0, exp_frames = 0, exp_errs = 0;
    logic [7:0] exp_p1 = 8'h00, exp_p2 = 8'h00, exp_ec = 8'h00;
    logic [3:0] shadow_m [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] seen_m = 4'h0;
    logic [10:0] last_in = 11'h0;
    logic [15:0] prev_sc = 16'h0;
    scoreboard_display_capture #(.STABLE_CYCLES(ST), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .segments_i(segments), .segment_select_i(segment_select),
        .p1_score_o(p1), .p2_score_o(p2), .frame_valid_o(fv), .decode_err_o(de), .err_count_o(ec)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Pulse tally plus a guard that scores only ever change while frame_valid is up.
    always @(negedge clk) begin
        if (fv) frames++;
        if (de) errs++;
        if (!rst && {p1, p2} !== prev_sc) check("atomic", {31'd0, fv}, 32'd1);
        prev_sc = {p1, p2};
    end
    function automatic int decode(input logic [6:0] p);
        if (p == 7'h00) return 0;
        for (int i = 0; i < 10; i++) if (LUT[i] == p) return i;
        return -1;
    endfunction
    task automatic item(input logic [3:0] sel, input logic [6:0] seg, input int h);
        int d;
        segment_select = sel;
        segments = seg;
        last_in = {sel, seg};
        repeat (h) @(negedge clk);
        if (h >= ST + 1 && $onehot(sel)) begin
            d = decode(seg);
            if (d < 0) begin
                exp_errs++;
                seen_m = 4'h0;
`ifdef SCOREBOARD_CAPTURE_ERRCNT_EN
                if (exp_ec != 8'hFF) exp_ec++;
`endif
            end else begin
                for (int i = 0; i < 4; i++) if (sel[i]) shadow_m[i] = 4'(d);
                seen_m |= sel;
                if (seen_m == 4'hF) begin
                    exp_p1 = {shadow_m[1], shadow_m[0]};
                    exp_p2 = {shadow_m[3], shadow_m[2]};
                    exp_frames++;
                    seen_m = 4'h0;
                end
            end
        end
        check("p1", {24'd0, p1}, {24'd0, exp_p1});
        check("p2", {24'd0, p2}, {24'd0, exp_p2});
        check("frames", frames, exp_frames);
        check("errs", errs, exp_errs);
        check("err_count", {24'd0, ec}, {24'd0, exp_ec});
    endtask
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_p1", {24'd0, p1}, 32'd0);
        check("rst_p2", {24'd0, p2}, 32'd0);
        check("rst_fv", {31'd0, fv}, 32'd0);
        check("rst_de", {31'd0, de}, 32'd0);
        check("rst_ec", {24'd0, ec}, 32'd0);
        item(4'b0001, 7'h4F, 7);
        item(4'b0010, 7'h06, 7);
        item(4'b0100, 7'h6D, 7);
        item(4'b1000, 7'h5B, 7);
        check("full_p1", {24'd0, p1}, 32'h13);
        check("full_p2", {24'd0, p2}, 32'h25);
        check("full_fv_cycles", frames, 1);
        item(4'b0001, 7'h06, 3);
        item(4'b0001, 7'h7F, 7);
        item(4'b0010, 7'h3F, 7);
        item(4'b0100, 7'h3F, 7);
        item(4'b1000, 7'h3F, 7);
        check("glitch_p1", {24'd0, p1}, 32'h08);
        item(4'b0001, 7'h66, 7);
        item(4'b0010, 7'h07, 7);
        item(4'b0100, 7'h12, 7);
        item(4'b1000, 7'h6F, 7);
        item(4'b0001, 7'h6D, 7);
        item(4'b0010, 7'h7D, 7);
        check("illegal_p1", {24'd0, p1}, 32'h08);
        check("illegal_frames", frames, 2);
        check("illegal_errs", errs, 1);
        item(4'b0001, 7'h12, 7);
        item(4'b0001, 7'h07, 7);
        item(4'b0000, 7'h5B, 5);
        item(4'b0010, 7'h00, 7);
        item(4'b0011, 7'h06, 7);
        item(4'b0100, 7'h3F, 7);
        item(4'b0000, 7'h00, 4);
        item(4'b1000, 7'h00, 7);
        check("blank_p1", {24'd0, p1}, 32'h07);
        check("blank_p2", {24'd0, p2}, 32'h00);
        for (int n = 0; n < 150; n++) begin
            logic [3:0] s;
            logic [6:0] g;
            int h;
            do begin
                s = $urandom_range(9) < 7 ? 4'(1 << $urandom_range(3)) : 4'($urandom_range(15));
                g = $urandom_range(7) == 0 ? 7'($urandom) : ($urandom_range(9) == 0 ? 7'h00 : LUT[$urandom_range(9)]);
            end while ({s, g} == last_in);
            h = $urandom_range(3) == 0 ? $urandom_range(1, 3) : $urandom_range(7, 9);
            item(s, g, h);
        end
        item(4'b0001, 7'h06, 7);
        item(4'b0010, 7'h5B, 7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_p1", {24'd0, p1}, 32'd0);
        check("mid_rst_p2", {24'd0, p2}, 32'd0);
        check("mid_rst_fv", {31'd0, fv}, 32'd0);
        check("mid_rst_de", {31'd0, de}, 32'd0);
        check("mid_rst_ec", {24'd0, ec}, 32'd0);
        for (int i = 0; i < 4; i++) shadow_m[i] = 4'd0;
        seen_m = 4'h0;
        exp_p1 = 8'h00;
        exp_p2 = 8'h00;
        exp_ec = 8'h00;
        @(negedge clk);
        segments = 7'h00;
        segment_select = 4'h0;
        last_in = 11'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_frames", frames, exp_frames);
        check("idle_errs", errs, exp_errs);
        check("idle_p1", {24'd0, p1}, 32'd0);
        for (int i = 0; i < 300; i++) item(4'b0100, i % 2 == 1 ? 7'h12 : 7'h13, 6);
`ifdef SCOREBOARD_CAPTURE_ERRCNT_EN
        check("errcnt_sat", {24'd0, ec}, 32'hFF);
`else
        check("errcnt_off", {24'd0, ec}, 32'h00);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
